// File: rtl/bitcounter_ctrl.sv
// Control FSM for a shift-and-count bit counter datapath shared by two
// requesters. Round-robin arbitration picks an owner, the operand is loaded
// into the datapath A register, A is shifted right while the result register
// counts ones, and the count is handed back through a four-phase done/req
// handshake.
module bitcounter_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] a_in,
  input  logic [CW-1:0]    result_in,
  output logic             clear,
  output logic             load_a,
  output logic             r_shift,
  output logic             incr,
  output logic [WIDTH-1:0] input_a,
  output logic [1:0]       grant,
  output logic [1:0]       done,
  output logic [CW-1:0]    count,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  logic   last;    // index of the requester served most recently
  logic   winner;  // index that wins arbitration this cycle
  logic   gidx;    // index of the current owner

  // A lone request wins outright; with both requesting, the one not served last wins.
  assign winner = (req == 2'b11) ? ~last : req[1];
  assign gidx   = grant[1];
  assign busy   = (state != IDLE);

  // State, owner and round-robin pointer; the operand itself lives in the datapath.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      grant <= 2'b00;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            grant <= winner ? 2'b10 : 2'b01;
            state <= COUNT;
          end
        end
        COUNT: begin
          if (a_in == '0) state <= DONE;
        end
        DONE: begin
          if (!req[gidx]) begin
            state <= IDLE;
            grant <= 2'b00;
            last  <= gidx;
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

  // Datapath controls decoded from state and live inputs; reset forces the datapath clear.
  always_comb begin
    clear   = 1'b0;
    load_a  = 1'b0;
    r_shift = 1'b0;
    incr    = 1'b0;
    input_a = '0;
    done    = 2'b00;
    if (!reset_n) begin
      clear = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          clear = 1'b1;
          if (req != 2'b00) begin
            load_a  = 1'b1;
            input_a = winner ? data1 : data0;
          end
        end
        COUNT: begin
          if (a_in != '0) begin
            r_shift = 1'b1;
            incr    = a_in[0];
          end
        end
        DONE: begin
          done = grant;
        end
        default: begin
          clear = 1'b0;
        end
      endcase
    end
  end

  // The result is only presented while the owner is being told it is done.
  assign count = (done != 2'b00) ? result_in : '0;

endmodule

// File: tb/tb_bitcounter_ctrl.sv
// Bench for bitcounter_ctrl: behavioural shift/count datapath around the
// controller, a table of hand-computed transactions, a reset-during-count
// sequence and randomized transactions scored against a round-robin model.
module tb_bitcounter_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] req;
  logic [7:0] data0, data1;
  logic [7:0] a_in;
  logic [3:0] result_in;
  logic       clear, load_a, r_shift, incr;
  logic [7:0] input_a;
  logic [1:0] grant, done;
  logic [3:0] count;
  logic       busy;

  int nvec = 0;
  int nmis = 0;

  bitcounter_ctrl #(.WIDTH(8), .CW(4)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .data0(data0), .data1(data1),
    .a_in(a_in), .result_in(result_in), .clear(clear), .load_a(load_a),
    .r_shift(r_shift), .incr(incr), .input_a(input_a), .grant(grant),
    .done(done), .count(count), .busy(busy)
  );

  always #5 clock = ~clock;

  // Datapath: A register loads or shifts right, result register clears or increments.
  logic [7:0] a_reg = 8'h00;
  logic [3:0] res_reg = 4'h0;
  always_ff @(posedge clock) begin
    if (load_a) a_reg <= input_a;
    else if (r_shift) a_reg <= a_reg >> 1;
    if (clear) res_reg <= 4'h0;
    else if (incr) res_reg <= res_reg + 4'h1;
  end
  assign a_in = a_reg;
  assign result_in = res_reg;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_latency(input logic [7:0] op);
    int k;
    k = -1;
    for (int i = 0; i < 8; i++) if (op[i]) k = i;
    return (k < 0) ? 1 : k + 2;
  endfunction

  // Runs one transaction from an IDLE cycle (entered just after a rising edge)
  // and returns just after the edge that brings the controller back to IDLE.
  task automatic serve(input logic [1:0] rq, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [1:0] eg, input logic [3:0] ec, input int hold,
                       input bit early);
    logic [7:0] op, shadow;
    int gi, lat;
    gi = eg[1] ? 1 : 0;
    op = gi ? d1 : d0;
    req = rq; data0 = d0; data1 = d1;
    @(negedge clock);
    check("idle_busy", busy, 0);
    check("idle_grant", grant, 0);
    check("idle_done", done, 0);
    check("idle_clear", clear, 1);
    check("grant_load_a", load_a, 1);
    check("grant_input_a", input_a, op);
    check("idle_r_shift", r_shift, 0);
    @(posedge clock); #1;
    data0 = ~d0; data1 = ~d1;
    if (early) req[gi] = 1'b0;
    shadow = op;
    lat = 0;
    forever begin
      @(negedge clock);
      if (done != 2'b00 || lat >= 40) break;
      check("count_grant", grant, eg);
      check("count_input_a", input_a, 0);
      check("count_ctrl", {load_a, clear}, 0);
      check("count_r_shift", r_shift, shadow != 0);
      check("count_incr", incr, (shadow != 0) && shadow[0]);
      shadow = shadow >> 1;
      lat++;
      @(posedge clock); #1;
    end
    check("count_latency", lat, exp_latency(op));
    check("done_vec", done, eg);
    check("done_count", count, ec);
    check("done_busy", busy, 1);
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        @(posedge clock); #1;
        @(negedge clock);
        check("hold_done", done, eg);
        check("hold_count", count, ec);
      end
      @(posedge clock); #1;
      req[gi] = 1'b0;
      @(negedge clock);
      check("exit_done", done, eg);
      check("exit_count", count, ec);
    end
    @(posedge clock); #1;
  endtask

  typedef struct {
    logic [1:0] rq;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] eg;
    logic [3:0] ec;
    int         hold;
    bit         early;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic       lastp;
    logic [1:0] rq;
    logic [7:0] d0, d1, op;
    int         w;
    bit         early;

    tbl[0] = '{2'b11, 8'h0F, 8'h03, 2'b01, 4'd4, 1, 1'b0};
    tbl[1] = '{2'b10, 8'h0F, 8'h03, 2'b10, 4'd2, 0, 1'b0};
    tbl[2] = '{2'b11, 8'h0F, 8'h03, 2'b01, 4'd4, 0, 1'b0};
    tbl[3] = '{2'b10, 8'h0F, 8'h03, 2'b10, 4'd2, 0, 1'b0};
    tbl[4] = '{2'b01, 8'hB5, 8'h00, 2'b01, 4'd5, 2, 1'b0};
    tbl[5] = '{2'b10, 8'h00, 8'h00, 2'b10, 4'd0, 1, 1'b0};
    tbl[6] = '{2'b01, 8'hFF, 8'h00, 2'b01, 4'd8, 0, 1'b0};
    tbl[7] = '{2'b01, 8'h3C, 8'h00, 2'b01, 4'd4, 0, 1'b1};
    tbl[8] = '{2'b11, 8'h01, 8'h80, 2'b10, 4'd1, 0, 1'b0};
    tbl[9] = '{2'b01, 8'h01, 8'h00, 2'b01, 4'd1, 0, 1'b0};

    // Reset with both requests high: datapath must be held cleared and idle.
    reset_n = 1'b0; req = 2'b11; data0 = 8'hAA; data1 = 8'h55;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_clear", clear, 1);
    check("rst_load_a", load_a, 0);
    check("rst_shift_incr", {r_shift, incr}, 0);
    check("rst_input_a", input_a, 0);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    @(posedge clock); #1;
    reset_n = 1'b1; req = 2'b00;

    // Hand-computed transaction table, starting from the reset pointer.
    for (int i = 0; i < 10; i++)
      serve(tbl[i].rq, tbl[i].d0, tbl[i].d1, tbl[i].eg, tbl[i].ec, tbl[i].hold, tbl[i].early);
    @(negedge clock);
    check("early_drop_idle", {busy, done}, 0);
    @(posedge clock); #1;

    // Reset in the third COUNT cycle abandons the operation.
    req = 2'b01; data0 = 8'h80; data1 = 8'h00;
    repeat (3) begin @(posedge clock); #1; end
    reset_n = 1'b0;
    @(negedge clock);
    check("midrst_clear", clear, 1);
    check("midrst_ctrl", {load_a, r_shift, incr}, 0);
    check("midrst_count", count, 0);
    @(posedge clock); #1;
    reset_n = 1'b1; req = 2'b00;
    @(negedge clock);
    check("postrst_busy", busy, 0);
    check("postrst_grant", grant, 0);
    check("postrst_done", done, 0);
    check("postrst_clear", clear, 1);
    @(posedge clock); #1;

    // Randomized transactions against the round-robin / popcount model.
    lastp = 1'b1;
    for (int n = 0; n < 60; n++) begin
      rq = 2'($urandom_range(1, 3));
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      if ($urandom_range(0, 5) == 0) d0 = 8'h00;
      if ($urandom_range(0, 5) == 0) d1 = d1 & 8'h0F;
      if (rq == 2'b11) w = lastp ? 0 : 1;
      else w = (rq == 2'b10) ? 1 : 0;
      op = (w == 1) ? d1 : d0;
      early = ($urandom_range(0, 3) == 0);
      serve(rq, d0, d1, 2'(1 << w), 4'($countones(op)), $urandom_range(0, 2), early);
      lastp = (w == 1);
    end
    req = 2'b00;
    repeat (2) @(posedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
